// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared widths, field indices and codeword types for the LED path
package led_pkg;

  localparam int CNT_W  = 8;
  localparam int CODE_W = 2 * CNT_W;

  localparam int RED_HI = CODE_W - 1;
  localparam int RED_LO = CNT_W;
  localparam int GRN_HI = CNT_W - 1;
  localparam int GRN_LO = 0;

  typedef logic [CNT_W-1:0]  field_t;
  typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/duty_meter.sv
// rtl/duty_meter.sv - per-colour high-cycle accumulator with saturation flag
module duty_meter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample,
  input  logic             frame_end,
  output logic [CNT_W-1:0] duty,
  output logic             sat
);

  localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};

  logic [CNT_W:0]   acc_q, acc_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             sat_q, sat_d;
  logic [CNT_W:0]   total;
  logic             full;

  // The frame-end sample is folded in here so the next frame starts from zero
  // without dropping a cycle.
  assign total = acc_q + {{CNT_W{1'b0}}, sample};
  assign full  = (total == FULL);

  always_comb begin
    acc_d  = acc_q;
    duty_d = duty_q;
    sat_d  = sat_q;
    if (clear) begin
      acc_d = '0;
    end else if (frame_end) begin
      acc_d  = '0;
      duty_d = full ? '1 : total[CNT_W-1:0];
      sat_d  = full;
    end else begin
      acc_d = total;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      duty_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      duty_q <= duty_d;
      sat_q  <= sat_d;
    end
  end

  assign duty = duty_q;
  assign sat  = sat_q;

endmodule

// File: rtl/led_decoder.sv
// rtl/led_decoder.sv - PWM duty decoder for red/green pins; LED_DECODER_SYNC_EN adds 2-flop pin synchronizers
module led_decoder #(
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               pin_r,
  input  logic               pin_g,
  output logic [2*CNT_W-1:0] code,
  output logic               code_valid,
  output logic               sat_r,
  output logic               sat_g
);

  import led_pkg::*;

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             code_valid_q, code_valid_d;
  logic             s_r, s_g;
  logic             clear, frame_end;

`ifdef LED_DECODER_SYNC_EN
  logic [1:0] sync_r_q, sync_g_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r_q <= '0;
      sync_g_q <= '0;
    end else begin
      sync_r_q <= {sync_r_q[0], pin_r};
      sync_g_q <= {sync_g_q[0], pin_g};
    end
  end

  assign s_r = sync_r_q[1];
  assign s_g = sync_g_q[1];
`else
  assign s_r = pin_r;
  assign s_g = pin_g;
`endif

  assign clear     = ~enable;
  assign frame_end = enable && (frame_cnt_q == '1);

  // Disabling restarts the frame so the next enable begins a full 2^CNT_W window.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    code_valid_d = 1'b0;
    if (enable) begin
      frame_cnt_d  = frame_cnt_q + 1'b1;
      code_valid_d = frame_end;
    end else begin
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      code_valid_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      code_valid_q <= code_valid_d;
    end
  end

  duty_meter #(.CNT_W(CNT_W)) u_red (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .sample    (s_r),
    .frame_end (frame_end),
    .duty      (code[2*CNT_W-1:CNT_W]),
    .sat       (sat_r)
  );

  duty_meter #(.CNT_W(CNT_W)) u_green (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .sample    (s_g),
    .frame_end (frame_end),
    .duty      (code[CNT_W-1:0]),
    .sat       (sat_g)
  );

  assign code_valid = code_valid_q;

endmodule

// File: tb/tb_led_decoder.sv
// tb/tb_led_decoder.sv - directed self-checking bench for led_decoder (handles LED_DECODER_SYNC_EN)
module tb_led_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        pin_r;
  logic        pin_g;
  logic [15:0] code;
  logic        code_valid;
  logic        sat_r;
  logic        sat_g;

  int checks = 0;
  int errors = 0;
  int ph;
  int dr;
  int dg;
  int n;
  logic seen;

  led_decoder #(.CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pin_r      (pin_r),
    .pin_g      (pin_g),
    .code       (code),
    .code_valid (code_valid),
    .sat_r      (sat_r),
    .sat_g      (sat_g)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PWM source: pin high while phase < duty, period 256
  task automatic drive();
    pin_r = (ph < dr);
    pin_g = (ph < dg);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    ph = (ph + 1) % 256;
    drive();
  endtask

  task automatic set_duty(input int r, input int g);
    dr = r;
    dg = g;
    drive();
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!code_valid && cnt < 600);
    check("valid_seen", {31'd0, code_valid}, 32'd1);
  endtask

  // With synchronizers the frame after a source change is shifted by 2 cycles.
  task automatic settle();
`ifdef LED_DECODER_SYNC_EN
    int skip;
    wait_valid(skip);
`endif
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    ph     = 0;
    set_duty(0, 0);
    repeat (3) cyc();
    check("rst_code", code, 16'h0000);
    check("rst_valid", code_valid, 1'b0);
    check("rst_sat_r", sat_r, 1'b0);
    check("rst_sat_g", sat_g, 1'b0);

    // 0x80 / 0x40 aligned to the frame
    reset  = 1'b0;
    enable = 1'b1;
    ph     = 0;
    set_duty(128, 64);
    wait_valid(n);
    check("first_latency", n, 256);
`ifndef LED_DECODER_SYNC_EN
    check("first_code", code, 16'h8040);
`endif
    wait_valid(n);
    check("period", n, 256);
    check("code_8040", code, 16'h8040);
    check("sat_r_8040", sat_r, 1'b0);
    check("sat_g_8040", sat_g, 1'b0);
    cyc();
    check("pulse_width", code_valid, 1'b0);
    wait_valid(n);
    check("period_after_pulse", n, 255);

    // red tied low, green tied high
    set_duty(0, 256);
    settle();
    wait_valid(n);
    check("period_tie", n, 256);
    check("code_00ff", code, 16'h00FF);
    check("sat_r_tie", sat_r, 1'b0);
    check("sat_g_tie", sat_g, 1'b1);

    // 0xFF / 0x01 with 37-cycle phase offset
    ph = (ph + 37) % 256;
    set_duty(255, 1);
    settle();
    wait_valid(n);
    check("code_ff01", code, 16'hFF01);
    check("sat_r_ff01", sat_r, 1'b0);
    check("sat_g_ff01", sat_g, 1'b0);

    // one-cycle reset at frame cycle 100
    repeat (100) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midrst_code", code, 16'h0000);
    check("midrst_valid", code_valid, 1'b0);
    check("midrst_sat_r", sat_r, 1'b0);
    wait_valid(n);
    check("midrst_latency", n, 256);
`ifndef LED_DECODER_SYNC_EN
    check("midrst_code_after", code, 16'hFF01);
`endif
    wait_valid(n);
    check("midrst_code_steady", code, 16'hFF01);

    // enable low for 300 cycles while the source changes
    enable = 1'b0;
    set_duty(16, 16);
    seen = 1'b0;
    repeat (300) begin
      cyc();
      if (code_valid) seen = 1'b1;
    end
    check("dis_no_valid", seen, 1'b0);
    check("dis_code_hold", code, 16'hFF01);
    enable = 1'b1;
    wait_valid(n);
    check("reen_latency", n, 256);
`ifndef LED_DECODER_SYNC_EN
    check("reen_code", code, 16'h1010);
`endif
    wait_valid(n);
    check("code_1010", code, 16'h1010);

    // source changes 0x10 -> 0x20 mid-frame
    repeat (128) cyc();
    set_duty(32, 32);
    wait_valid(n);
    check("mix_r_range", (code[15:8] >= 8'h10 && code[15:8] <= 8'h20), 1'b1);
    check("mix_g_range", (code[7:0] >= 8'h10 && code[7:0] <= 8'h20), 1'b1);
    wait_valid(n);
    check("code_2020", code, 16'h2020);
    wait_valid(n);
    check("code_2020_again", code, 16'h2020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_decoder.md
Name: led_decoder

Overview:
- Measures the duty cycle of the two LED PWM pins (red, green) and reconstructs the 16-bit colour codeword {red[7:0], green[7:0]} that the LED driver consumed.
- Used as a loopback checker on the LED drive path, and as a decoder for externally supplied PWM colour inputs.
- Counts high cycles over fixed frames of 2^CNT_W clocks. The frame length equals the PWM period, so the count equals the codeword regardless of phase.

Parameters:
- CNT_W, 8: PWM/frame counter width. Frame length is 2^CNT_W cycles. Each colour field is CNT_W bits.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  measurement enable; low holds the decoder idle
- pin_r  input  1  red PWM pin being measured
- pin_g  input  1  green PWM pin being measured
- code  output  2*CNT_W  decoded codeword; [2*CNT_W-1:CNT_W] is red, [CNT_W-1:0] is green
- code_valid  output  1  one-cycle pulse when code updates
- sat_r  output  1  red pin was high for every cycle of the last frame
- sat_g  output  1  green pin was high for every cycle of the last frame

Behaviour:
- Reset (synchronous, active-high): frame_cnt=0, both accumulators=0, code=0, code_valid=0, sat_r=0, sat_g=0. Reset overrides enable.
- Sampling: each enabled cycle, s_r/s_g = pin_r/pin_g (direct, or synchronized; see Optional Feature).
- Each enabled cycle: frame_cnt increments, wrapping at 2^CNT_W. Each accumulator (CNT_W+1 bits) adds its sample.
- Frame end is the cycle where frame_cnt == 2^CNT_W-1. On that edge:
  - total = acc + current sample.
  - code field = (total == 2^CNT_W) ? all-ones : total[CNT_W-1:0].
  - sat_x = (total == 2^CNT_W).
  - code_valid = 1 for exactly one cycle.
  - Accumulators load 0. The next frame starts with no lost sample.
- code and sat_x hold between frame ends.
- enable low:
  - frame_cnt and accumulators are cleared to 0.
  - code and sat_x hold their values; code_valid = 0.
  - On the cycle enable returns high, the first sample of a new frame is taken. The first code_valid follows 2^CNT_W enabled cycles later.
- Latency: pin level to code visibility is at most 2^CNT_W cycles, plus synchronizer depth when that feature is enabled.
- Mid-frame codeword change at the source: the frame reports the partial-sum mix. The next full frame reports the new value exactly.
- Reset mid-frame: the partial frame is discarded. The next code_valid comes exactly 2^CNT_W cycles after reset deasserts (enable high).
- Wrap of frame_cnt coincides with frame end. There are no other simultaneous events.

Optional Feature:
- Macro: LED_DECODER_SYNC_EN.
- Defined:
  - pin_r and pin_g each pass through a 2-flop synchronizer (reset to 0) before sampling. Latency is +2 cycles.
  - The first frame after reset or enable may undercount by up to 2. Benches must ignore that frame.
- Undefined: pins are sampled directly. The source must be synchronous to clock.

Decomposition:
- Shared package led_pkg holds:
  - CNT_W default (8), CODE_W = 2*CNT_W;
  - field index constants RED_HI/RED_LO/GRN_HI/GRN_LO;
  - a typedef for the colour field and one for the full codeword. The driver side uses the same typedefs.
- Sub-module duty_meter, instantiated once per colour:
  - ports: clock, reset, clear, sample, frame_end, duty, sat;
  - contents: accumulator and saturation logic.
- The top level owns frame_cnt, enable handling, the synchronizer, and code_valid.

Test Plan:
- Drive PWM codewords red=0x80, green=0x40 (period 256) -> code=16'h8040 with code_valid every 256 cycles, sat_r=sat_g=0, from the first frame.
- pin_r tied 0, pin_g tied 1 -> code=16'h00FF, sat_r=0, sat_g=1.
- PWM 0xFF/0x01 at arbitrary phase offset (e.g. 37 cycles) -> code=16'hFF01, no saturation.
- Assert reset at frame cycle 100 for 1 cycle -> code=0 and code_valid=0 next cycle; next code_valid exactly 256 cycles after reset deasserts, value correct.
- enable low for 300 cycles -> no code_valid pulse and code holds its prior value; re-enable -> code_valid after 256 cycles.
- Source changes 0x10 to 0x20 mid-frame -> one transitional value between 0x10 and 0x20, then 0x20 on every later frame. With LED_DECODER_SYNC_EN, repeat the first scenario ignoring frame 1.
